fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the main decoder in the LEGv8 core.
- Holds the PC and issues word requests to instruction memory over a req/ack handshake.
- Captures each returned 32-bit instruction and presents it with its PC and opcode field op = instr[31:21], which drives the decoder's Op input.
- Handles downstream stall and branch redirect, including a redirect while a request is outstanding.

Parameters:
- N, 64: PC / address width in bits.
- RESET_PC, 0: PC value loaded on reset. Low 2 bits must be 0.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (reset = 0 clears all state immediately).
- imem_req  out  1  fetch request, registered.
- imem_addr  out  N  fetch address, registered; equals current PC.
- imem_ack  in  1  memory has valid data on imem_rdata this cycle; meaningful only while imem_req = 1.
- imem_rdata  in  32  instruction word.
- stall  in  1  downstream cannot accept the presented instruction.
- branch_taken  in  1  redirect request, one-cycle pulse.
- branch_target  in  N  redirect address; bits [1:0] are ignored and forced to 0.
- instr_valid  out  1  instr / instr_pc / op hold a valid instruction.
- instr  out  32  captured instruction.
- instr_pc  out  N  PC of the captured instruction.
- op  out  11  instr[31:21], fed to the main decoder Op.

Behaviour:
- Reset (async, reset = 0):
  - state = IDLE; pc = RESET_PC; flush = 0.
  - imem_req = 0; imem_addr = RESET_PC.
  - instr_valid = 0; instr = 0; instr_pc = 0; op = 0.
  - Asserting reset mid-fetch abandons the request: req drops immediately, and any ack in that cycle is ignored.
- FSM states: IDLE, FETCH, HOLD.
- IDLE: on the next edge go to FETCH with imem_req = 1 and imem_addr = pc.
- FETCH:
  - imem_req stays 1 and imem_addr stays stable until ack.
  - ack, flush = 0: capture instr = imem_rdata, op = imem_rdata[31:21], instr_pc = pc; instr_valid = 1; req = 0; go to HOLD.
  - ack, flush = 1: discard the data; clear flush; stay in FETCH with addr = pc (the redirected PC) and req = 1. Because req stays high, the new address is presented the next cycle.
  - branch_taken without ack: pc = target; flush = 1; req and addr unchanged (the outstanding request must complete).
  - branch_taken with ack in the same cycle: discard the data; pc = target; flush = 0; stay in FETCH with addr = target.
- HOLD:
  - instr_valid = 1; outputs hold stable.
  - stall = 1, no branch: remain in HOLD, outputs unchanged.
  - stall = 0, no branch: instruction consumed at this edge; pc = pc + 4; instr_valid = 0; go to FETCH with req = 1 and addr = pc + 4.
  - branch_taken (any stall value): presented instruction dropped; pc = target; instr_valid = 0; go to FETCH with addr = target. Branch has priority over stall.
- Timing: with zero-wait memory (ack in the first req cycle), one instruction every 2 cycles. The first instr_valid appears 2 cycles after reset release.
- Arithmetic: pc + 4 is modulo 2^N, so all-ones-aligned + 4 wraps to 0.
- op is always instr[31:21], including when instr_valid = 0.
- imem_ack while imem_req = 0 is ignored.

Test Plan:
- Release reset with ack tied high in every req cycle, rdata = 32'hF8400000 → first edge: req = 1, addr = 0. Next edge: instr_valid = 1, op = 11'h7C2, instr_pc = 0. Then addr = 4.
- Ack delayed 3 cycles → req and addr = 0 held stable for all 3 cycles; instr captured only on the ack edge; instr_valid = 0 until then.
- HOLD with stall = 1 for 4 cycles → instr, op and instr_pc unchanged, req = 0. Drop stall → next edge pc = 4, req = 1.
- In HOLD, branch_taken = 1 with target 64'h103 (stall = 1) → instr_valid = 0, addr = 64'h100, req = 1.
- In FETCH at addr 8, branch to 64'h40 two cycles before ack → req/addr stay 8 until ack. Acked data is discarded (instr_valid stays 0). Then addr = 64'h40, and the next ack is captured with instr_pc = 64'h40.
- Assert reset mid-FETCH with ack = 1 in the same cycle → immediately req = 0, instr_valid = 0, pc = RESET_PC; no capture.
- Branch to 64'hFFFF_FFFF_FFFF_FFFC, consume → next fetch addr = 0.

Source files
------------

// File: rtl/fetch_unit.sv
// LEGv8 instruction fetch stage: holds the PC, fetches words over a req/ack
// handshake and presents instr / instr_pc / op to the main decoder.
module fetch_unit #(
  parameter int unsigned       N        = 64,
  parameter logic [N-1:0]      RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [31:0]  imem_rdata,
  input  logic         stall,
  input  logic         branch_taken,
  input  logic [N-1:0] branch_target,
  output logic         instr_valid,
  output logic [31:0]  instr,
  output logic [N-1:0] instr_pc,
  output logic [10:0]  op
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [N-1:0] pc_q,    pc_d;
  logic         flush_q, flush_d;
  logic         req_q,   req_d;
  logic [N-1:0] addr_q,  addr_d;
  logic         valid_q, valid_d;
  logic [31:0]  instr_q, instr_d;
  logic [N-1:0] ipc_q,   ipc_d;

  logic [N-1:0] target;
  logic [N-1:0] pc_plus4;
  logic         ack;

  assign target   = branch_target & {{(N-2){1'b1}}, 2'b00};
  assign pc_plus4 = pc_q + N'(4);
  // An ack is only meaningful against an outstanding request.
  assign ack      = imem_ack & req_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flush_d = flush_q;
    req_d   = req_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
        req_d   = 1'b1;
        addr_d  = pc_q;
      end
      FETCH: begin
        if (ack) begin
          if (branch_taken) begin
            pc_d    = target;
            flush_d = 1'b0;
            req_d   = 1'b1;
            addr_d  = target;
          end else if (flush_q) begin
            // Stale response to a pre-redirect address: drop it and refetch.
            flush_d = 1'b0;
            req_d   = 1'b1;
            addr_d  = pc_q;
          end else begin
            instr_d = imem_rdata;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            req_d   = 1'b0;
            state_d = HOLD;
          end
        end else if (branch_taken) begin
          pc_d    = target;
          flush_d = 1'b1;
        end
      end
      HOLD: begin
        if (branch_taken) begin
          pc_d    = target;
          valid_d = 1'b0;
          req_d   = 1'b1;
          addr_d  = target;
          state_d = FETCH;
        end else if (!stall) begin
          pc_d    = pc_plus4;
          valid_d = 1'b0;
          req_d   = 1'b1;
          addr_d  = pc_plus4;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      flush_q <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= '0;
      ipc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flush_q <= flush_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  assign op          = instr_q[31:21];

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed fetch/stall/branch/reset vectors,
// expected captures queued by stimulus and checked by a valid-edge monitor.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        instr_valid;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic [10:0] op;

  typedef struct {
    logic [31:0] i;
    logic [63:0] pc;
    logic [10:0] op;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic prev_valid = 1'b0;

  fetch_unit #(.N(64), .RESET_PC(64'h0)) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .op           (op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] i, input logic [63:0] pc, input logic [10:0] o);
    exp_t e;
    e.i = i; e.pc = pc; e.op = o;
    sb.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: each new presentation (rising instr_valid) consumes one expectation.
  always @(negedge clk) begin
    if (reset && instr_valid && !prev_valid) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_capture", {32'h0, instr}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_instr", {32'h0, instr}, {32'h0, e.i});
        chk("sb_pc", instr_pc, e.pc);
        chk("sb_op", {53'h0, op}, {53'h0, e.op});
      end
    end
    prev_valid <= reset ? instr_valid : 1'b0;
  end

  initial begin
    reset = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {63'h0, imem_req}, 64'h0);
    chk("rst_addr", imem_addr, 64'h0);
    chk("rst_valid", {63'h0, instr_valid}, 64'h0);
    chk("rst_instr", {32'h0, instr}, 64'h0);
    chk("rst_pc", instr_pc, 64'h0);
    chk("rst_op", {53'h0, op}, 64'h0);

    // Zero-wait fetch after reset release
    imem_ack = 1'b1; imem_rdata = 32'hF840_0000;
    push(32'hF840_0000, 64'h0, 11'h7C2);
    reset = 1'b1;
    cyc();
    chk("first_req", {63'h0, imem_req}, 64'h1);
    chk("first_addr", imem_addr, 64'h0);
    chk("first_valid0", {63'h0, instr_valid}, 64'h0);
    cyc();
    chk("first_valid", {63'h0, instr_valid}, 64'h1);
    chk("first_req_drop", {63'h0, imem_req}, 64'h0);
    cyc();
    chk("next_req", {63'h0, imem_req}, 64'h1);
    chk("next_addr", imem_addr, 64'h4);

    // Ack delayed 3 cycles
    imem_ack = 1'b0;
    repeat (3) begin
      cyc();
      chk("wait_req", {63'h0, imem_req}, 64'h1);
      chk("wait_addr", imem_addr, 64'h4);
      chk("wait_valid", {63'h0, instr_valid}, 64'h0);
    end
    imem_ack = 1'b1; imem_rdata = 32'h8B02_0020; stall = 1'b1;
    push(32'h8B02_0020, 64'h4, 11'h458);
    cyc();
    chk("late_valid", {63'h0, instr_valid}, 64'h1);
    chk("late_req", {63'h0, imem_req}, 64'h0);

    // Stall in HOLD; stray acks while req=0 must be ignored
    imem_rdata = 32'h1234_5678;
    repeat (4) begin
      cyc();
      chk("stall_valid", {63'h0, instr_valid}, 64'h1);
      chk("stall_req", {63'h0, imem_req}, 64'h0);
      chk("stall_instr", {32'h0, instr}, 64'h8B02_0020);
      chk("stall_pc", instr_pc, 64'h4);
      chk("stall_op", {53'h0, op}, 64'h458);
    end
    stall = 1'b0;
    cyc();
    chk("unstall_req", {63'h0, imem_req}, 64'h1);
    chk("unstall_addr", imem_addr, 64'h8);
    chk("unstall_valid", {63'h0, instr_valid}, 64'h0);

    // Redirect while request to 8 is outstanding
    imem_ack = 1'b0; branch_taken = 1'b1; branch_target = 64'h40;
    cyc();
    branch_taken = 1'b0;
    chk("fbr_req", {63'h0, imem_req}, 64'h1);
    chk("fbr_addr", imem_addr, 64'h8);
    cyc();
    chk("fbr_addr_hold", imem_addr, 64'h8);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    cyc();
    chk("flush_valid", {63'h0, instr_valid}, 64'h0);
    chk("flush_req", {63'h0, imem_req}, 64'h1);
    chk("flush_addr", imem_addr, 64'h40);
    imem_rdata = 32'hF800_0000;
    push(32'hF800_0000, 64'h40, 11'h7C0);
    cyc();
    chk("redir_valid", {63'h0, instr_valid}, 64'h1);

    // Branch in HOLD beats stall; target low bits forced to 0
    imem_ack = 1'b0; stall = 1'b1; branch_taken = 1'b1; branch_target = 64'h103;
    cyc();
    branch_taken = 1'b0; stall = 1'b0;
    chk("hbr_valid", {63'h0, instr_valid}, 64'h0);
    chk("hbr_req", {63'h0, imem_req}, 64'h1);
    chk("hbr_addr", imem_addr, 64'h100);
    imem_ack = 1'b1; imem_rdata = 32'hD280_0000;
    push(32'hD280_0000, 64'h100, 11'h694);
    cyc();
    chk("hbr_cap", {63'h0, instr_valid}, 64'h1);
    imem_ack = 1'b0;
    cyc();
    chk("seq_addr", imem_addr, 64'h104);

    // Branch coincident with ack in FETCH
    imem_ack = 1'b1; imem_rdata = 32'h1111_1111; branch_taken = 1'b1; branch_target = 64'h200;
    cyc();
    branch_taken = 1'b0;
    chk("bra_valid", {63'h0, instr_valid}, 64'h0);
    chk("bra_req", {63'h0, imem_req}, 64'h1);
    chk("bra_addr", imem_addr, 64'h200);
    imem_rdata = 32'h9100_0000;
    push(32'h9100_0000, 64'h200, 11'h488);
    cyc();
    chk("bra_cap", {63'h0, instr_valid}, 64'h1);

    // PC wrap at top of address space
    imem_ack = 1'b0; branch_taken = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFFE;
    cyc();
    branch_taken = 1'b0;
    chk("top_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    imem_ack = 1'b1; imem_rdata = 32'hAA00_0000;
    push(32'hAA00_0000, 64'hFFFF_FFFF_FFFF_FFFC, 11'h550);
    cyc();
    chk("top_cap", {63'h0, instr_valid}, 64'h1);
    imem_ack = 1'b0;
    cyc();
    chk("wrap_addr", imem_addr, 64'h0);
    chk("wrap_req", {63'h0, imem_req}, 64'h1);

    // Asynchronous reset mid-FETCH with ack present
    imem_ack = 1'b1; imem_rdata = 32'hF840_0000;
    #2 reset = 1'b0;
    #1;
    chk("arst_req", {63'h0, imem_req}, 64'h0);
    chk("arst_valid", {63'h0, instr_valid}, 64'h0);
    chk("arst_addr", imem_addr, 64'h0);
    chk("arst_instr", {32'h0, instr}, 64'h0);
    chk("arst_op", {53'h0, op}, 64'h0);
    cyc();
    chk("arst_hold_req", {63'h0, imem_req}, 64'h0);
    chk("arst_hold_instr", {32'h0, instr}, 64'h0);
    imem_ack = 1'b0;
    reset = 1'b1;
    cyc();
    chk("rerel_req", {63'h0, imem_req}, 64'h1);
    chk("rerel_addr", imem_addr, 64'h0);
    chk("rerel_valid", {63'h0, instr_valid}, 64'h0);
    repeat (2) cyc();
    chk("sb_drained", 64'(sb.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
